fifo_packer: RTL

Downstream consumer of `fifo_flops`. Drains `width`-bit words through the FIFO's `pndng`/`pop` interface and packs `ratio` consecutive words into one `width*ratio` output beat. The beat is presented on a valid/ready interface, and a `flush` input forces a partially filled beat out. It sits between the FIFO output and the wide-bus consumer, and is driven in the bench through the same interface style as the FIFO.

---
 rtl/fifo_packer_if.sv | 25 ++
 rtl/fifo_packer.sv | 71 +++++++
 2 files changed

// File: rtl/fifo_packer_if.sv
// Bundle between a fifo_flops read port, the packer and the wide-bus consumer.
// The master side is the packer; the slave side is the FIFO/consumer environment.
interface fifo_packer_if #(
  parameter int width = 16,
  parameter int ratio = 4
);
  logic                       pndng;
  logic [width-1:0]           fifo_dout;
  logic                       pop;
  logic                       flush;
  logic [width*ratio-1:0]     out_data;
  logic [$clog2(ratio):0]     out_cnt;
  logic                       out_valid;
  logic                       out_ready;

  modport master (
    input  pndng, fifo_dout, flush, out_ready,
    output pop, out_data, out_cnt, out_valid
  );

  modport slave (
    output pndng, fifo_dout, flush, out_ready,
    input  pop, out_data, out_cnt, out_valid
  );
endinterface

// File: rtl/fifo_packer.sv
// Packs `ratio` consecutive FIFO words into one wide beat on a valid/ready port.
// A flush forces out a partially filled beat; unused lanes read zero.
module fifo_packer #(
  parameter int width = 16,
  parameter int ratio = 4
) (
  input  logic          clk,
  input  logic          rst,
  fifo_packer_if.master bus
);
  localparam int CW = $clog2(ratio) + 1;
  localparam int AW = width * ratio;

  typedef enum logic {FILL, HOLD} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] acc;
  logic          valid;
  logic          pop;
  logic [CW-1:0] cnt_inc;

  // Pop request and post-pop lane count; no pop while reset is asserted.
  always_comb begin
    pop     = 1'b0;
    if (rst) begin
      pop = (state == HOLD) ? (bus.out_ready & bus.pndng) : bus.pndng;
    end
    cnt_inc = cnt + CW'(pop);
  end

  assign bus.pop       = pop;
  assign bus.out_data  = acc;
  assign bus.out_cnt   = cnt;
  assign bus.out_valid = valid;

  // FILL collects words lane by lane; HOLD presents the beat until accepted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= FILL;
      cnt   <= '0;
      acc   <= '0;
      valid <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (pop) begin
            for (int unsigned i = 0; i < unsigned'(ratio); i++) begin
              if (cnt == CW'(i)) acc[i*width +: width] <= bus.fifo_dout;
            end
            cnt <= cnt_inc;
          end
          if ((cnt_inc == CW'(ratio)) || (bus.flush && (cnt_inc != '0))) begin
            state <= HOLD;
            valid <= 1'b1;
          end
        end
        HOLD: begin
          // Handshake clears the beat; a same-cycle pop seeds lane 0 of the next one.
          if (bus.out_ready) begin
            state <= FILL;
            valid <= 1'b0;
            acc   <= pop ? AW'(bus.fifo_dout) : '0;
            cnt   <= pop ? CW'(1) : '0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule
